// File: rtl/spike_rate_encoder.sv
// spike_rate_encoder: accepts one vector of per-channel intensities over a
// valid/ready handshake and plays it out as a deterministic rate-coded spike
// train of NUM_TIMESTEPS timesteps, one timestep per cycle with step_en high.
// Each channel spikes on the carry-out of a W-bit phase accumulator, so after
// t steps channel i has fired floor(t*I_i / 2^W) times.
//
// Ports:
//   clk, rst      clock, asynchronous active-high reset
//   in_valid      intensity vector present
//   in_ready      encoder idle, will accept a vector
//   intensity_in  packed intensities, channel i at [i*W +: W]
//   step_en       advance one timestep this cycle
//   spike_out     one-cycle spike pulses, one bit per channel
//   spike_valid   a timestep was emitted this cycle
//   last          final timestep of the presentation
//   busy          presentation in progress

// One channel: intensity latch, phase accumulator and registered carry.
module spike_rate_encoder_lane #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic         step,
  input  logic [W-1:0] intensity,
  output logic         spike
);
  logic [W-1:0] level;
  logic [W-1:0] acc;
  logic [W:0]   sum;

  assign sum = {1'b0, acc} + {1'b0, level};

  // load only happens in IDLE and step only in RUN, so they never collide.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      level <= '0;
      acc   <= '0;
      spike <= 1'b0;
    end else begin
      spike <= 1'b0;
      if (load) begin
        level <= intensity;
        acc   <= '0;
      end else if (step) begin
        acc   <= sum[W-1:0];
        spike <= sum[W];
      end
    end
  end
endmodule

module spike_rate_encoder #(
  parameter int NUM_INPUTS      = 4,
  parameter int INTENSITY_WIDTH = 8,
  parameter int NUM_TIMESTEPS   = 16
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic                                  in_valid,
  output logic                                  in_ready,
  input  logic [NUM_INPUTS*INTENSITY_WIDTH-1:0] intensity_in,
  input  logic                                  step_en,
  output logic [NUM_INPUTS-1:0]                 spike_out,
  output logic                                  spike_valid,
  output logic                                  last,
  output logic                                  busy
);
  localparam int              SW     = $clog2(NUM_TIMESTEPS + 1);
  localparam logic [SW-1:0]   S_LAST = SW'(NUM_TIMESTEPS - 1);

  typedef enum logic {IDLE, RUN} state_t;

  state_t        state_q, state_d;
  logic [SW-1:0] step_cnt;
  logic          load, step, final_step;

  assign in_ready   = (state_q == IDLE);
  assign busy       = (state_q == RUN);
  assign load       = in_valid & in_ready;
  assign step       = busy & step_en;
  // Step that brings the counter to T closes the presentation.
  assign final_step = step & (step_cnt == S_LAST);

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (load)       state_d = RUN;
      RUN:     if (final_step) state_d = IDLE;
      default:                 state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      step_cnt    <= '0;
      spike_valid <= 1'b0;
      last        <= 1'b0;
    end else begin
      state_q     <= state_d;
      spike_valid <= step;
      last        <= final_step;
      if (load)      step_cnt <= '0;
      else if (step) step_cnt <= step_cnt + SW'(1);
    end
  end

  for (genvar i = 0; i < NUM_INPUTS; i++) begin : g_lane
    spike_rate_encoder_lane #(.W(INTENSITY_WIDTH)) u_lane (
      .clk       (clk),
      .rst       (rst),
      .load      (load),
      .step      (step),
      .intensity (intensity_in[i*INTENSITY_WIDTH +: INTENSITY_WIDTH]),
      .spike     (spike_out[i])
    );
  end
endmodule

// File: tb/tb_spike_rate_encoder.sv
module tb_spike_rate_encoder;
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // T=16 instance
  logic        iv = 1'b0, se = 1'b0;
  logic [31:0] din = '0;
  logic        ir, sv, lst, bsy;
  logic [3:0]  so;

  // T=8 instance
  logic        iv8 = 1'b0, se8 = 1'b0;
  logic [31:0] din8 = '0;
  logic        ir8, sv8, lst8, bsy8;
  logic [3:0]  so8;

  spike_rate_encoder #(.NUM_INPUTS(4), .INTENSITY_WIDTH(8), .NUM_TIMESTEPS(16)) dut16 (
    .clk(clk), .rst(rst), .in_valid(iv), .in_ready(ir), .intensity_in(din),
    .step_en(se), .spike_out(so), .spike_valid(sv), .last(lst), .busy(bsy)
  );

  spike_rate_encoder #(.NUM_INPUTS(4), .INTENSITY_WIDTH(8), .NUM_TIMESTEPS(8)) dut8 (
    .clk(clk), .rst(rst), .in_valid(iv8), .in_ready(ir8), .intensity_in(din8),
    .step_en(se8), .spike_out(so8), .spike_valid(sv8), .last(lst8), .busy(bsy8)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Runs one presentation on dut16, recording per-step spikes per channel.
  // already: handshake was set up in the previous call's last cycle.
  // hold_alt: keep in_valid high with a different vector during RUN.
  // chain: present nxt in the last cycle for a back-to-back handshake.
  task automatic run16(input logic [31:0] vec, input bit gated, input bit already,
                       input bit hold_alt, input logic [31:0] alt,
                       input bit chain, input logic [31:0] nxt,
                       output logic [3:0][15:0] pat, output int nvalid);
    int s, cyc;
    bit prev, done;
    pat = '0; nvalid = 0; s = 0; done = 0; cyc = 0;
    if (!already) begin
      @(negedge clk); din = vec; iv = 1'b1;
    end
    @(negedge clk);
    chk("hs_busy_ready", {bsy, ir}, 2'b10);
    iv = hold_alt;
    if (hold_alt) din = alt;
    se = 1'b1; prev = 1'b1;
    while (!done && cyc < 80) begin
      @(negedge clk); cyc++;
      chk("valid_follows_step", sv, prev);
      if (sv) begin
        if (s < 16) for (int c = 0; c < 4; c++) pat[c][s] = so[c];
        s++; nvalid++;
        chk("last_flag", lst, (s == 16));
        if (lst) begin
          done = 1;
          chk("idle_at_last", {bsy, ir}, 2'b01);
        end
      end else begin
        chk("gap_quiet", {so, lst}, 5'b0);
      end
      if (!done) begin
        se = gated ? ~se : 1'b1;
        prev = se;
      end
    end
    chk("run_completes", done, 1);
    se = 1'b0;
    if (chain) begin iv = 1'b1; din = nxt; end
    else iv = 1'b0;
  endtask

  logic [3:0][15:0] pat;
  int               n;
  logic [7:0]       p8;
  logic             other8;
  int               n8, s8;
  bit               d8;

  initial begin
    // Reset asserted with no clock edge yet
    #1 rst = 1'b1;
    #2;
    chk("rst16_outputs", {so, sv, lst, bsy, ir}, 8'b0000_0001);
    chk("rst8_outputs",  {so8, sv8, lst8, bsy8, ir8}, 8'b0000_0001);
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // Reset mid-idle, between edges
    @(negedge clk); #2 rst = 1'b1; #1;
    chk("rst_idle", {so, sv, lst, bsy, ir}, 8'b0000_0001);
    @(negedge clk); rst = 1'b0;

    // Half rate, T=8, ch0=128
    @(negedge clk); din8 = 32'h0000_0080; iv8 = 1'b1;
    @(negedge clk); iv8 = 1'b0; se8 = 1'b1;
    p8 = '0; n8 = 0; s8 = 0; d8 = 0; other8 = 1'b0;
    for (int c = 0; c < 40 && !d8; c++) begin
      @(negedge clk);
      if (sv8) begin
        if (s8 < 8) p8[s8] = so8[0];
        other8 |= |so8[3:1];
        s8++; n8++;
        if (lst8) begin d8 = 1; chk("half_last_step", s8, 8); end
      end
    end
    se8 = 1'b0;
    chk("half_done", d8, 1);
    chk("half_ch0_pattern", p8, 8'hAA);
    chk("half_valid_count", n8, 8);
    chk("half_others_quiet", other8, 0);

    // Mixed vector {0,64,255,128}, T=16
    run16(32'h0040_FF80, 0, 0, 0, '0, 0, '0, pat, n);
    chk("mix_ch0", pat[0], 16'hAAAA);
    chk("mix_ch1", pat[1], 16'hFFFE);
    chk("mix_ch2", pat[2], 16'h8888);
    chk("mix_ch3", pat[3], 16'h0000);
    chk("mix_valid_count", n, 16);

    // Gated stepping, ch0=128
    run16(32'h0000_0080, 1, 0, 0, '0, 0, '0, pat, n);
    chk("gated_ch0", pat[0], 16'hAAAA);
    chk("gated_others", pat[1] | pat[2] | pat[3], 16'h0000);
    chk("gated_valid_count", n, 16);

    // Busy rejection, then back-to-back handshake in the last cycle.
    // ch1=255 leaves 240 in its accumulator, so a missed clear would spike on step 1.
    run16(32'h0040_FF80, 0, 0, 1, 32'hFFFF_FFFF, 1, 32'h0040_FF80, pat, n);
    chk("reject_ch0", pat[0], 16'hAAAA);
    chk("reject_ch1", pat[1], 16'hFFFE);
    chk("reject_ch2", pat[2], 16'h8888);
    chk("reject_ch3", pat[3], 16'h0000);
    run16(32'h0040_FF80, 0, 1, 0, '0, 0, '0, pat, n);
    chk("b2b_ch1", pat[1], 16'hFFFE);
    chk("b2b_ch0", pat[0], 16'hAAAA);
    chk("b2b_ch2", pat[2], 16'h8888);
    chk("b2b_valid_count", n, 16);

    // Reset mid-RUN
    @(negedge clk); din = 32'h0040_FF80; iv = 1'b1;
    @(negedge clk); iv = 1'b0; se = 1'b1;
    repeat (3) @(negedge clk);
    chk("pre_rst_running", {sv, bsy}, 2'b11);
    #2 rst = 1'b1; #1;
    chk("rst_run", {so, sv, lst, bsy, ir}, 8'b0000_0001);
    @(negedge clk); rst = 1'b0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      chk("post_rst_quiet", {so, sv, lst, bsy, ir}, 8'b0000_0001);
    end
    se = 1'b0;

    // All channels full scale, then step_en in IDLE must do nothing
    run16(32'hFFFF_FFFF, 0, 0, 0, '0, 0, '0, pat, n);
    chk("full_ch0", pat[0], 16'hFFFE);
    chk("full_ch3", pat[3], 16'hFFFE);
    se = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      chk("idle_step_quiet", {so, sv, lst, bsy}, 7'b0);
    end
    se = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
